bram_debug_port_ctrl: RTL and testbench

//  Sequencer that owns port 2 (A2/WD2/WE2/RD2) of the Inst or Data BRAM. It takes LOAD and DUMP

---
 rtl/bram_dbg_pkg.sv | 19 +
 rtl/bram_dbg_addr_gen.sv | 39 +++
 rtl/bram_debug_port_ctrl.sv | 142 ++++++++++++++
 tb/tb_bram_debug_port_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_dbg_pkg.sv
// Shared types and constants for the BRAM debug-port sequencer.
// Used by the top controller and its address generator.
package bram_dbg_pkg;

  localparam int BRAMWORDS_DEFAULT = 4096;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRD,
    S_DWAIT,
    S_DOUT,
    S_FIN
  } state_t;

endpackage

// File: rtl/bram_dbg_addr_gen.sv
// Word-index walker for one command: loads base/count, steps per transferred word,
// wraps at the end of the BRAM and flags the final word.
module bram_dbg_addr_gen #(
  parameter int IW = 12,
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [IW-1:0] i_base,
  input  logic [CW-1:0] i_count,
  input  logic          i_step,
  output logic [IW-1:0] o_idx,
  output logic [IW-1:0] o_next_idx,
  output logic          o_last
);

  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_left;

  // IW-bit index arithmetic gives the wrap at the end of the BRAM for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_idx  <= i_base;
      r_left <= i_count;
    end else if (i_step) begin
      r_idx  <= r_idx + IW'(1);
      r_left <= r_left - CW'(1);
    end
  end

  assign o_idx      = r_idx;
  assign o_next_idx = r_idx + IW'(1);
  assign o_last     = (r_left == CW'(1));

endmodule

// File: rtl/bram_debug_port_ctrl.sv
// LOAD/DUMP sequencer owning port 2 of an instruction or data BRAM; holds the
// core in reset while a command runs and streams words over valid/ready links.
module bram_debug_port_ctrl
  import bram_dbg_pkg::*;
#(
  parameter int BRAMWORDS = BRAMWORDS_DEFAULT,
  parameter int AW        = 32,
  parameter int CW        = 13
) (
  input  logic          CPU_CLK,
  input  logic          CPU_RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [CW-1:0] cmd_count,
  input  logic          abort,
  input  logic [31:0]   ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic [31:0]   dp_data,
  output logic [AW-1:0] dp_addr,
  output logic          dp_valid,
  input  logic          dp_ready,
  output logic [AW-1:0] bram_a2,
  output logic [31:0]   bram_wd2,
  output logic [3:0]    bram_we2,
  input  logic [31:0]   bram_rd2,
  output logic          busy,
  output logic          core_hold,
  output logic          done,
  output logic          aborted
);

  localparam int IW = $clog2(BRAMWORDS);
  localparam logic [CW-1:0] MAXCNT = CW'(BRAMWORDS);

  state_t r_state, w_next;

  logic [AW-1:0] r_a2, r_dp_addr;
  logic [31:0]   r_wd2, r_dp_data;
  logic [3:0]    r_we2;
  logic          r_aborted;

  logic [CW-1:0] w_count;
  logic [IW-1:0] w_base_word, w_idx, w_next_idx;
  logic          w_last, w_accept, w_ld_hs, w_dp_hs, w_active, w_abort, w_step;
  logic          w_unused_base;

  assign w_count       = (cmd_count > MAXCNT) ? MAXCNT : cmd_count;
  assign w_base_word   = cmd_base[IW+1:2];
  assign w_unused_base = ^{cmd_base[AW-1:IW+2], cmd_base[1:0]};

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_ld_hs  = (r_state == S_LOAD) && ld_valid;
  assign w_dp_hs  = (r_state == S_DOUT) && dp_ready;
  assign w_active = (r_state == S_LOAD) || (r_state == S_DRD) ||
                    (r_state == S_DWAIT) || (r_state == S_DOUT);
  assign w_abort  = abort && w_active;
  assign w_step   = (w_ld_hs || w_dp_hs) && !abort;

  bram_dbg_addr_gen #(.IW(IW), .CW(CW)) u_addr_gen (
    .clk        (CPU_CLK),
    .rst        (CPU_RST),
    .i_load     (w_accept),
    .i_base     (w_base_word),
    .i_count    (w_count),
    .i_step     (w_step),
    .o_idx      (w_idx),
    .o_next_idx (w_next_idx),
    .o_last     (w_last)
  );

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_count == '0)          w_next = S_FIN;
          else if (cmd_op == OP_DUMP) w_next = S_DRD;
          else                        w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_ld_hs && w_last) w_next = S_FIN;
      S_DRD:   w_next = S_DWAIT;
      S_DWAIT: w_next = S_DOUT;
      S_DOUT:  if (dp_ready) w_next = w_last ? S_FIN : S_DRD;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_FIN;
  end

  // The read address is set on entry to DRD so the synchronous BRAM output is
  // settled by the end of DWAIT, giving three cycles per dumped word.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_a2      <= '0;
      r_wd2     <= '0;
      r_we2     <= 4'h0;
      r_dp_data <= '0;
      r_dp_addr <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_we2 <= 4'h0;
      if (w_ld_hs && !abort) begin
        r_a2  <= {{(AW-IW-2){1'b0}}, w_idx, 2'b00};
        r_wd2 <= ld_data;
        r_we2 <= 4'hF;
      end else if (w_accept && cmd_op == OP_DUMP) begin
        r_a2 <= {{(AW-IW-2){1'b0}}, w_base_word, 2'b00};
      end else if (w_dp_hs && !w_last && !abort) begin
        r_a2 <= {{(AW-IW-2){1'b0}}, w_next_idx, 2'b00};
      end
      if (r_state == S_DWAIT) begin
        r_dp_data <= bram_rd2;
        r_dp_addr <= r_a2;
      end
      if (w_accept)     r_aborted <= 1'b0;
      else if (w_abort) r_aborted <= 1'b1;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign core_hold = busy;
  assign done      = (r_state == S_FIN);
  assign aborted   = (r_state == S_FIN) && r_aborted;
  assign ld_ready  = (r_state == S_LOAD);
  assign dp_valid  = (r_state == S_DOUT);
  assign dp_data   = r_dp_data;
  assign dp_addr   = r_dp_addr;
  assign bram_a2   = r_a2;
  assign bram_wd2  = r_wd2;
  assign bram_we2  = r_we2;

endmodule

// File: tb/tb_bram_debug_port_ctrl.sv
// Directed bench for bram_debug_port_ctrl with a behavioural synchronous BRAM on port 2.
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_bram_debug_port_ctrl;

  logic        CPU_CLK, CPU_RST;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_base;
  logic [12:0] cmd_count;
  logic        abort;
  logic [31:0] ld_data;
  logic        ld_valid, ld_ready;
  logic [31:0] dp_data, dp_addr;
  logic        dp_valid, dp_ready;
  logic [31:0] bram_a2, bram_wd2, bram_rd2;
  logic [3:0]  bram_we2;
  logic        busy, core_hold, done, aborted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:4095];

  bram_debug_port_ctrl dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .abort(abort),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .dp_data(dp_data), .dp_addr(dp_addr), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .bram_a2(bram_a2), .bram_wd2(bram_wd2), .bram_we2(bram_we2), .bram_rd2(bram_rd2),
    .busy(busy), .core_hold(core_hold), .done(done), .aborted(aborted)
  );

  initial begin
    CPU_CLK = 1'b0;
    forever #5 CPU_CLK = ~CPU_CLK;
  end

  // Behavioural BRAM port 2: synchronous read, full-word write.
  always @(posedge CPU_CLK) begin
    if (bram_we2 == 4'hF) mem[bram_a2[13:2]] <= bram_wd2;
    bram_rd2 <= mem[bram_a2[13:2]];
  end

  task automatic test_reset();
    CPU_RST = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
    abort = 1'b0; ld_data = '0; ld_valid = 1'b0; dp_ready = 1'b0;
    @(negedge CPU_CLK); @(negedge CPU_CLK);
    total++;
    if ({cmd_ready, busy, core_hold, done, aborted, ld_ready, dp_valid} !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 1000000",
               {cmd_ready, busy, core_hold, done, aborted, ld_ready, dp_valid});
    end
    total++;
    if (bram_we2 !== 4'h0 || bram_a2 !== 32'h0 || bram_wd2 !== 32'h0 || dp_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_regs: got we=%h a2=%h wd=%h dp=%h want all 0",
               bram_we2, bram_a2, bram_wd2, dp_data);
    end
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
  endtask

  task automatic test_load_basic();
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 32'h0; cmd_count = 13'd4;
    ld_valid = 1'b1; ld_data = 32'hA0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    total++;
    if ({ld_ready, core_hold, cmd_ready} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL load_state: got %b want 110", {ld_ready, core_hold, cmd_ready});
    end
    for (int i = 0; i < 4; i++) begin
      ld_data = 32'hA0 + i;
      @(negedge CPU_CLK);
      total++;
      if (bram_we2 !== 4'hF || bram_a2 !== 32'(4 * i) || bram_wd2 !== 32'hA0 + i) begin
        bad++;
        $display("[TB] FAIL load_write%0d: got we=%h a2=%h wd=%h want F %h %h",
                 i, bram_we2, bram_a2, bram_wd2, 32'(4 * i), 32'hA0 + i);
      end
    end
    total++;
    if (done !== 1'b1 || ld_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_done: got done=%b ld_ready=%b want 1 0", done, ld_ready);
    end
    ld_valid = 1'b0;
    @(negedge CPU_CLK);
    total++;
    if ({bram_we2, done, core_hold, cmd_ready} !== 7'b0000001) begin
      bad++;
      $display("[TB] FAIL load_end: got we=%h done=%b hold=%b cmd_ready=%b want 0 0 0 1",
               bram_we2, done, core_hold, cmd_ready);
    end
  endtask

  task automatic test_dump_basic();
    logic [31:0] exp_addr [2];
    logic [31:0] exp_data [2];
    int k = 0;
    int we_hits = 0;
    logic seen_done = 1'b0;
    exp_addr[0] = 32'h8; exp_data[0] = 32'hA2;
    exp_addr[1] = 32'hC; exp_data[1] = 32'hA3;
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 32'h8; cmd_count = 13'd2; dp_ready = 1'b1;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (bram_we2 !== 4'h0) we_hits++;
      if (dp_valid && dp_ready) begin
        total++;
        if (k >= 2 || dp_addr !== exp_addr[k] || dp_data !== exp_data[k]) begin
          bad++;
          $display("[TB] FAIL dump_word%0d: got (%h,%h) want (%h,%h)", k, dp_addr, dp_data,
                   exp_addr[k % 2], exp_data[k % 2]);
        end
        k++;
      end
      if (done) seen_done = 1'b1;
      @(negedge CPU_CLK);
    end
    total++;
    if (!seen_done || k != 2 || we_hits != 0) begin
      bad++;
      $display("[TB] FAIL dump_summary: got done=%b words=%0d we_hits=%0d want 1 2 0",
               seen_done, k, we_hits);
    end
  endtask

  task automatic test_dump_backpressure();
    int k = 0;
    int unstable = 0;
    logic seen_done = 1'b0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] prev_addr = '0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 32'h0; cmd_count = 13'd3; dp_ready = 1'b0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      dp_ready = ~dp_ready;
      if (prev_hold && (dp_valid !== 1'b1 || dp_data !== prev_data || dp_addr !== prev_addr))
        unstable++;
      if (dp_valid && dp_ready) begin
        total++;
        if (dp_addr !== 32'(4 * k) || dp_data !== 32'hA0 + k) begin
          bad++;
          $display("[TB] FAIL bp_word%0d: got (%h,%h) want (%h,%h)", k, dp_addr, dp_data,
                   32'(4 * k), 32'hA0 + k);
        end
        k++;
      end
      prev_hold = dp_valid && !dp_ready;
      prev_data = dp_data;
      prev_addr = dp_addr;
      if (done) seen_done = 1'b1;
      @(negedge CPU_CLK);
    end
    dp_ready = 1'b0;
    total++;
    if (!seen_done || k != 3 || unstable != 0) begin
      bad++;
      $display("[TB] FAIL bp_summary: got done=%b words=%0d unstable=%0d want 1 3 0",
               seen_done, k, unstable);
    end
  endtask

  task automatic test_load_wrap_gaps();
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 32'h3FFC; cmd_count = 13'd2; ld_valid = 1'b0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0; ld_valid = 1'b1; ld_data = 32'hB0;
    @(negedge CPU_CLK);
    total++;
    if (bram_we2 !== 4'hF || bram_a2 !== 32'h3FFC || bram_wd2 !== 32'hB0) begin
      bad++;
      $display("[TB] FAIL wrap_write0: got we=%h a2=%h wd=%h want F 3ffc b0",
               bram_we2, bram_a2, bram_wd2);
    end
    ld_valid = 1'b0;
    @(negedge CPU_CLK);
    total++;
    if (bram_we2 !== 4'h0 || ld_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_gap: got we=%h ld_ready=%b want 0 1", bram_we2, ld_ready);
    end
    ld_valid = 1'b1; ld_data = 32'hB1;
    @(negedge CPU_CLK);
    total++;
    if (bram_we2 !== 4'hF || bram_a2 !== 32'h0 || bram_wd2 !== 32'hB1 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_write1: got we=%h a2=%h wd=%h done=%b want F 0 b1 1",
               bram_we2, bram_a2, bram_wd2, done);
    end
    ld_valid = 1'b0;
    @(negedge CPU_CLK);
    total++;
    if (mem[12'hFFF] !== 32'hB0 || mem[0] !== 32'hB1) begin
      bad++;
      $display("[TB] FAIL wrap_mem: got %h %h want b0 b1", mem[12'hFFF], mem[0]);
    end
  endtask

  task automatic test_count_limits();
    int writes = 0;
    logic seen_done = 1'b0;
    logic [31:0] last_a2 = '0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 32'h0; cmd_count = 13'd0; ld_valid = 1'b1;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    total++;
    if (done !== 1'b1 || ld_ready !== 1'b0 || bram_we2 !== 4'h0) begin
      bad++;
      $display("[TB] FAIL zero_count: got done=%b ld_ready=%b we=%h want 1 0 0",
               done, ld_ready, bram_we2);
    end
    @(negedge CPU_CLK);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || bram_we2 !== 4'h0) begin
      bad++;
      $display("[TB] FAIL zero_end: got done=%b cmd_ready=%b we=%h want 0 1 0",
               done, cmd_ready, bram_we2);
    end
    cmd_valid = 1'b1; cmd_count = 13'd5000; ld_data = 32'h5A5A0000;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    for (int c = 0; c < 4300 && !seen_done; c++) begin
      ld_data = ld_data + 32'd1;
      @(negedge CPU_CLK);
      if (bram_we2 == 4'hF) begin
        writes++;
        last_a2 = bram_a2;
      end
      if (done) seen_done = 1'b1;
    end
    ld_valid = 1'b0;
    total++;
    if (!seen_done || writes != 4096 || last_a2 !== 32'h3FFC) begin
      bad++;
      $display("[TB] FAIL clamp_count: got done=%b writes=%0d last_a2=%h want 1 4096 3ffc",
               seen_done, writes, last_a2);
    end
    @(negedge CPU_CLK);
  endtask

  task automatic test_abort_and_reset();
    int writes = 0;
    logic seen_dv = 1'b0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 32'h100; cmd_count = 13'd5; ld_valid = 1'b1;
    ld_data = 32'hC0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_data = 32'hC0 + i;
      @(negedge CPU_CLK);
      if (bram_we2 == 4'hF) writes++;
    end
    total++;
    if (writes != 2 || bram_a2 !== 32'h104) begin
      bad++;
      $display("[TB] FAIL abort_pre: got writes=%0d a2=%h want 2 104", writes, bram_a2);
    end
    abort = 1'b1; ld_data = 32'hC2;
    @(negedge CPU_CLK);
    abort = 1'b0; ld_valid = 1'b0;
    total++;
    if (bram_we2 !== 4'h0 || done !== 1'b1 || aborted !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_end: got we=%h done=%b aborted=%b want 0 1 1",
               bram_we2, done, aborted);
    end
    @(negedge CPU_CLK);
    total++;
    if (aborted !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_idle: got aborted=%b cmd_ready=%b want 0 1", aborted, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 32'h0; cmd_count = 13'd3; dp_ready = 1'b0;
    @(negedge CPU_CLK);
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && !seen_dv; c++) begin
      if (dp_valid) seen_dv = 1'b1;
      else @(negedge CPU_CLK);
    end
    total++;
    if (!seen_dv) begin
      bad++;
      $display("[TB] FAIL rst_wait: got dp_valid=0 want 1 within 10 cycles");
    end
    CPU_RST = 1'b1;
    #1;
    total++;
    if (dp_valid !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_dump: got dv=%b busy=%b hold=%b want 0 0 0",
               dp_valid, busy, core_hold);
    end
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_release: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  initial begin
    $display("[TB] starting bram_debug_port_ctrl bench");
    test_reset();
    test_load_basic();
    test_dump_basic();
    test_dump_backpressure();
    test_load_wrap_gaps();
    test_count_limits();
    test_abort_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
